// File: rtl/pipe_array_gen.sv
`timescale 1ns/1ps
// pipe_array_gen
//   Scrolling obstacle ("pipe") generator for a side-scroller playfield.
//   Keeps NUM_PIPES pipes evenly spaced by PIPE_SPACING.
//   - While running, every pipe moves left by STEP = speed+1 pixels per tick.
//   - A pipe that would move past x=0 wraps forward by one full period
//     P = NUM_PIPES*PIPE_SPACING. This keeps the spacing between pipes exact.
//     The wrapped pipe also gets a new random gap height taken from a 16-bit LFSR.
//   - Each pipe whose right edge crosses the score line SL = BIRD_HPOS-BIRD_XW
//     adds one point to a saturating 8-bit score.
//
// Ports
//   clk_2ms      in   1              game tick clock, rising edge
//   rst_n        in   1              synchronous active-low reset
//   state        in   2              0 ready (hold at init), 1 running, 2/3 frozen
//   speed        in   2              STEP = speed+1 pixels per tick
//   pip_X        out  NUM_PIPES*XW   pipe i right-edge X at [i*XW +: XW]
//   pip_Y        out  NUM_PIPES*9    pipe i gap-bottom Y at [i*9 +: 9]
//   score        out  8              pipes passed, saturates at 255
//   score_pulse  out  1              one-cycle flag, the cycle after score changed
module pipe_array_gen #(
    parameter int          NUM_PIPES    = 3,
    parameter int          XW           = 11,
    parameter int          SCREEN_W     = 640,
    parameter int          SCREEN_H     = 480,
    parameter int          SLOT_W       = 100,
    parameter int          SLOT_H       = 100,
    parameter int          PIPE_SPACING = 260,
    parameter int          BIRD_HPOS    = 320,
    parameter int          BIRD_XW      = 34,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                      clk_2ms,
    input  logic                      rst_n,
    input  logic [1:0]                state,
    input  logic [1:0]                speed,
    output logic [NUM_PIPES*XW-1:0]   pip_X,
    output logic [NUM_PIPES*9-1:0]    pip_Y,
    output logic [7:0]                score,
    output logic                      score_pulse
);

    localparam int         PERIOD  = NUM_PIPES * PIPE_SPACING;
    localparam int         SL      = BIRD_HPOS - BIRD_XW;
    localparam int         Y0      = (SCREEN_H + SLOT_H) / 2;
    localparam logic [8:0] Y_RANGE = 9'(SCREEN_H - SLOT_H);
    localparam logic [1:0] ST_READY = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;

    logic [XW-1:0] r_x [NUM_PIPES];
    logic [8:0]    r_y [NUM_PIPES];
    logic [7:0]    r_score;
    logic          r_changed;
    logic          r_pulse;
    logic [15:0]   r_lfsr;

    logic [XW-1:0]        w_step;
    logic [XW-1:0]        w_x_next [NUM_PIPES];
    logic [8:0]           w_y_next [NUM_PIPES];
    logic [NUM_PIPES-1:0] w_pass;
    logic [3:0]           w_pass_cnt;
    logic [8:0]           w_score_sum;
    logic [7:0]           w_score_next;
    logic [8:0]           w_rand_r;
    logic [8:0]           w_rand_y;
    logic                 w_lfsr_fb;

    assign w_step = XW'(speed) + XW'(1);

    // Taps 16,14,13,11. A shift-left Fibonacci LFSR never reaches zero from a non-zero seed.
    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    // Fold the 0..511 sample into the 0..(SCREEN_H-SLOT_H-1) window.
    // A single subtraction is enough because 511 < 2*(SCREEN_H-SLOT_H).
    assign w_rand_r = r_lfsr[8:0];
    assign w_rand_y = 9'(SLOT_H) + ((w_rand_r >= Y_RANGE) ? (w_rand_r - Y_RANGE) : w_rand_r);

    always_comb begin
        w_pass_cnt = '0;
        w_pass     = '0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            w_x_next[i] = r_x[i];
            w_y_next[i] = r_y[i];
            if (r_x[i] >= w_step) begin
                w_x_next[i] = r_x[i] - w_step;
                // A crossing is judged over the whole step, so every speed catches it.
                w_pass[i]   = (r_x[i] > XW'(SL)) && ((r_x[i] - w_step) <= XW'(SL));
            end else begin
                // Wrap by exactly one period. The result is below PERIOD, so it always fits in XW bits.
                w_x_next[i] = r_x[i] + XW'(PERIOD) - w_step;
                w_y_next[i] = w_rand_y;
            end
            w_pass_cnt = w_pass_cnt + 4'(w_pass[i]);
        end
    end

    assign w_score_sum  = {1'b0, r_score} + 9'(w_pass_cnt);
    assign w_score_next = (w_score_sum > 9'd255) ? 8'hFF : w_score_sum[7:0];

    always_ff @(posedge clk_2ms) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PIPES; i++) begin
                r_x[i] <= XW'(SCREEN_W + SLOT_W + i * PIPE_SPACING);
                r_y[i] <= 9'(Y0);
            end
            r_score   <= '0;
            r_changed <= 1'b0;
            r_pulse   <= 1'b0;
            r_lfsr    <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
            case (state)
                ST_READY: begin
                    for (int i = 0; i < NUM_PIPES; i++) begin
                        r_x[i] <= XW'(SCREEN_W + SLOT_W + i * PIPE_SPACING);
                        r_y[i] <= 9'(Y0);
                    end
                    r_score   <= '0;
                    r_changed <= 1'b0;
                    r_pulse   <= 1'b0;
                end
                ST_RUN: begin
                    for (int i = 0; i < NUM_PIPES; i++) begin
                        r_x[i] <= w_x_next[i];
                        r_y[i] <= w_y_next[i];
                    end
                    r_score   <= w_score_next;
                    r_changed <= (w_score_next != r_score);
                    r_pulse   <= r_changed;
                end
                default: begin
                    r_changed <= 1'b0;
                    r_pulse   <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        pip_X = '0;
        pip_Y = '0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            pip_X[i*XW +: XW] = r_x[i];
            pip_Y[i*9 +: 9]   = r_y[i];
        end
    end

    assign score       = r_score;
    assign score_pulse = r_pulse;

endmodule

// File: tb/tb_pipe_array_gen.sv
`timescale 1ns/1ps
module tb_pipe_array_gen;

    localparam int NP   = 3;
    localparam int XW   = 11;
    localparam int P    = 780;
    localparam int SL   = 286;
    localparam logic [15:0] SEED = 16'hACE1;

    logic              clk_2ms = 1'b0;
    logic              rst_n   = 1'b0;
    logic [1:0]        state   = 2'd0;
    logic [1:0]        speed   = 2'd0;
    logic [NP*XW-1:0]  pip_X;
    logic [NP*9-1:0]   pip_Y;
    logic [7:0]        score;
    logic              score_pulse;

    int n_pass  = 0;
    int n_total = 0;
    int n_print = 0;

    int          mx [NP];
    int          my [NP];
    int          mscore;
    bit          mpulse;
    bit          mchanged;
    logic [15:0] mlfsr;

    logic [NP*XW-1:0] x0_pk;
    logic [NP*9-1:0]  y0_pk;

    pipe_array_gen dut (
        .clk_2ms     (clk_2ms),
        .rst_n       (rst_n),
        .state       (state),
        .speed       (speed),
        .pip_X       (pip_X),
        .pip_Y       (pip_Y),
        .score       (score),
        .score_pulse (score_pulse)
    );

    always #5 clk_2ms = ~clk_2ms;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    function automatic logic [15:0] lfsr_next(logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic int rand_y(logic [15:0] v);
        int r;
        r = int'(v[8:0]);
        if (r >= 380) r = r - 380;
        return 100 + r;
    endfunction

    function automatic int dx(int i);
        return int'(pip_X[i*XW +: XW]);
    endfunction

    function automatic int dy(int i);
        return int'(pip_Y[i*9 +: 9]);
    endfunction

    function automatic logic [NP*XW-1:0] exp_x();
        logic [NP*XW-1:0] v;
        v = '0;
        for (int i = 0; i < NP; i++) v[i*XW +: XW] = XW'(mx[i]);
        return v;
    endfunction

    function automatic logic [NP*9-1:0] exp_y();
        logic [NP*9-1:0] v;
        v = '0;
        for (int i = 0; i < NP; i++) v[i*9 +: 9] = 9'(my[i]);
        return v;
    endfunction

    task automatic model_init();
        for (int i = 0; i < NP; i++) begin
            mx[i] = 740 + i * 260;
            my[i] = 290;
        end
        mscore   = 0;
        mpulse   = 0;
        mchanged = 0;
    endtask

    task automatic model_step();
        logic [15:0] cur;
        int step, cnt, ns;
        if (!rst_n) begin
            model_init();
            mlfsr = SEED;
        end else begin
            cur   = mlfsr;
            mlfsr = lfsr_next(mlfsr);
            if (state == 2'd0) begin
                model_init();
            end else if (state == 2'd1) begin
                step = int'(speed) + 1;
                cnt  = 0;
                for (int i = 0; i < NP; i++) begin
                    if (mx[i] >= step) begin
                        if (mx[i] > SL && mx[i] - step <= SL) cnt++;
                        mx[i] = mx[i] - step;
                    end else begin
                        mx[i] = mx[i] + P - step;
                        my[i] = rand_y(cur);
                    end
                end
                ns = mscore + cnt;
                if (ns > 255) ns = 255;
                mpulse   = mchanged;
                mchanged = (ns != mscore);
                mscore   = ns;
            end else begin
                mpulse   = 0;
                mchanged = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk_2ms);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        state = 2'd0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        state = 2'd1;
        speed = 2'd3;
        tick();
        n_total++;
        if (pip_X !== x0_pk) $display("FAIL reset_x: got %h expected %h", pip_X, x0_pk);
        else n_pass++;
        n_total++;
        if (pip_Y !== y0_pk) $display("FAIL reset_y: got %h expected %h", pip_Y, y0_pk);
        else n_pass++;
        n_total++;
        if (score !== 8'd0 || score_pulse !== 1'b0)
            $display("FAIL reset_score: got score %0d pulse %b expected 0 0", score, score_pulse);
        else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_score_line();
        do_reset();
        state = 2'd1;
        speed = 2'd0;
        repeat (453) tick();
        n_total++;
        if (score !== 8'd0) $display("FAIL pre_score: got %0d expected 0", score);
        else n_pass++;
        tick();
        n_total++;
        if (dx(0) !== 286 || score !== 8'd1 || score_pulse !== 1'b0)
            $display("FAIL score_line_454: got x0 %0d score %0d pulse %b expected 286 1 0", dx(0), score, score_pulse);
        else n_pass++;
        tick();
        n_total++;
        if (score_pulse !== 1'b1 || score !== 8'd1)
            $display("FAIL score_pulse_455: got pulse %b score %0d expected 1 1", score_pulse, score);
        else n_pass++;
        tick();
        n_total++;
        if (score_pulse !== 1'b0) $display("FAIL score_pulse_456: got %b expected 0", score_pulse);
        else n_pass++;
    endtask

    task automatic test_respawn();
        do_reset();
        state = 2'd1;
        speed = 2'd0;
        repeat (740) tick();
        n_total++;
        if (dx(0) !== 0) $display("FAIL respawn_740: got x0 %0d expected 0", dx(0));
        else n_pass++;
        tick();
        n_total++;
        if (dx(0) !== 779 || dx(1) !== 259 || dx(2) !== 519)
            $display("FAIL respawn_741_x: got %0d %0d %0d expected 779 259 519", dx(0), dx(1), dx(2));
        else n_pass++;
        n_total++;
        if (dy(0) < 100 || dy(0) > 479 || dy(0) !== my[0])
            $display("FAIL respawn_741_y: got %0d expected %0d in [100,479]", dy(0), my[0]);
        else n_pass++;
        n_total++;
        if (dy(1) !== 290 || dy(2) !== 290 || score !== 8'd2)
            $display("FAIL respawn_741_rest: got y1 %0d y2 %0d score %0d expected 290 290 2", dy(1), dy(2), score);
        else n_pass++;
    endtask

    task automatic test_fast();
        do_reset();
        state = 2'd1;
        speed = 2'd3;
        repeat (113) tick();
        n_total++;
        if (dx(0) !== 288 || score !== 8'd0)
            $display("FAIL fast_113: got x0 %0d score %0d expected 288 0", dx(0), score);
        else n_pass++;
        tick();
        n_total++;
        if (dx(0) !== 284 || score !== 8'd1)
            $display("FAIL fast_114: got x0 %0d score %0d expected 284 1", dx(0), score);
        else n_pass++;
    endtask

    task automatic test_freeze();
        logic [NP*XW-1:0] sx;
        logic [NP*9-1:0]  sy;
        int ss, bad;
        do_reset();
        state = 2'd1;
        speed = 2'($urandom_range(0, 3));
        repeat (50) tick();
        sx  = exp_x();
        sy  = exp_y();
        ss  = mscore;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            state = 2'($urandom_range(2, 3));
            speed = 2'($urandom_range(0, 3));
            tick();
            if (pip_X !== sx || pip_Y !== sy || score !== 8'(ss) || score_pulse !== 1'b0) bad++;
        end
        n_total++;
        if (bad != 0) $display("FAIL freeze_hold: got %0d moving cycles expected 0", bad);
        else n_pass++;
        state = 2'd0;
        tick();
        n_total++;
        if (pip_X !== x0_pk || pip_Y !== y0_pk || score !== 8'd0 || score_pulse !== 1'b0)
            $display("FAIL freeze_ready: got x %h y %h score %0d expected x %h y %h score 0", pip_X, pip_Y, score, x0_pk, y0_pk);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        do_reset();
        state = 2'd1;
        speed = 2'd1;
        repeat (300) tick();
        rst_n = 1'b0;
        tick();
        n_total++;
        if (pip_X !== x0_pk || pip_Y !== y0_pk || score !== 8'd0 || score_pulse !== 1'b0)
            $display("FAIL mid_reset: got x %h y %h score %0d pulse %b expected x %h y %h 0 0", pip_X, pip_Y, score, score_pulse, x0_pk, y0_pk);
        else n_pass++;
        rst_n = 1'b1;
        speed = 2'd3;
        repeat (200) tick();
        n_total++;
        if (dy(0) !== my[0] || dx(0) !== mx[0])
            $display("FAIL mid_reset_lfsr: got x0 %0d y0 %0d expected %0d %0d", dx(0), dy(0), mx[0], my[0]);
        else n_pass++;
    endtask

    task automatic test_random();
        int run_left;
        do_reset();
        run_left = 0;
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            if (run_left == 0) begin
                run_left = $urandom_range(5, 200);
                case ($urandom_range(0, 9))
                    0:       state = 2'd0;
                    1:       state = 2'd2;
                    2:       state = 2'd3;
                    default: state = 2'd1;
                endcase
            end
            run_left--;
            if ($urandom_range(0, 7) == 0) speed = 2'($urandom_range(0, 3));
            tick();
            n_total++;
            if (pip_X !== exp_x() || pip_Y !== exp_y() || score !== 8'(mscore) || score_pulse !== mpulse) begin
                if (n_print < 10)
                    $display("FAIL random_cycle_%0d: got x %h y %h s %0d p %b expected x %h y %h s %0d p %b",
                             c, pip_X, pip_Y, score, score_pulse, exp_x(), exp_y(), mscore, mpulse);
                n_print++;
            end else n_pass++;
        end
        rst_n = 1'b1;
    endtask

    task automatic test_saturate();
        int guard, bad;
        do_reset();
        state = 2'd1;
        speed = 2'd3;
        guard = 0;
        while (mscore < 255 && guard < 20000) begin
            tick();
            guard++;
        end
        n_total++;
        if (guard >= 20000 || score !== 8'd255)
            $display("FAIL sat_reach: got score %0d after %0d ticks expected 255", score, guard);
        else n_pass++;
        tick();
        n_total++;
        if (score_pulse !== 1'b1 || score !== 8'd255)
            $display("FAIL sat_last_pulse: got pulse %b score %0d expected 1 255", score_pulse, score);
        else n_pass++;
        bad = 0;
        for (int c = 0; c < 800; c++) begin
            speed = 2'($urandom_range(0, 3));
            tick();
            if (score !== 8'd255 || score_pulse !== 1'b0) bad++;
        end
        n_total++;
        if (bad != 0) $display("FAIL sat_hold: got %0d bad cycles expected 0", bad);
        else n_pass++;
    endtask

    initial begin
        x0_pk = {11'd1260, 11'd1000, 11'd740};
        y0_pk = {9'd290, 9'd290, 9'd290};
        model_init();
        mlfsr = SEED;
        test_reset();
        test_score_line();
        test_respawn();
        test_fast();
        test_freeze();
        test_mid_reset();
        test_random();
        test_saturate();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipe_array_gen.md
PIPE_ARRAY_GEN -- requirements
Module: pipe_array_gen

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 Parameter NUM_PIPES, default 3: number of concurrent pipes; legal range 1..8.
REQ-003 Parameter XW, default 11: width of each pipe X coordinate.
REQ-004 Parameter SCREEN_W, default 640; SCREEN_H, default 480: playfield size in pixels.
REQ-005 Parameter SLOT_W, default 100; SLOT_H, default 100: gap width and height.
REQ-006 Parameter PIPE_SPACING, default 260: X distance between consecutive pipes; NUM_PIPES*PIPE_SPACING SHALL be >= SCREEN_W+SLOT_W.
REQ-007 Parameter BIRD_HPOS, default 320; BIRD_XW, default 34: score line SL = BIRD_HPOS-BIRD_XW (286).
REQ-008 Parameter LFSR_SEED, default 16'hACE1: non-zero LFSR seed.
REQ-009 Port clk_2ms, input, 1: game tick clock; all logic on its rising edge.
REQ-010 Port rst_n, input, 1: synchronous active-low reset.
REQ-011 Port state, input, 2: 0 = ready, 1 = running, 2/3 = frozen (dead/paused).
REQ-012 Port speed, input, 2: step per tick, STEP = speed+1 (1..4 px); sampled every cycle.
REQ-013 Port pip_X, output, NUM_PIPES*XW: packed X of each pipe's right edge; pipe i at bits [i*XW +: XW].
REQ-014 Port pip_Y, output, NUM_PIPES*9: packed gap-bottom Y; pipe i at bits [i*9 +: 9].
REQ-015 Port score, output, 8: pipes passed, saturating.
REQ-016 Port score_pulse, output, 1: high for exactly the cycle after score increments.

Function
REQ-017 Init values: X0[i] = SCREEN_W+SLOT_W+i*PIPE_SPACING (740, 1000, 1260); Y0 = (SCREEN_H+SLOT_H)/2 (290).
REQ-018 Period P = NUM_PIPES*PIPE_SPACING (780); every pip_X SHALL stay < 2^XW.
REQ-019 state 0: all pip_X to X0[i], all pip_Y to Y0, score to 0, score_pulse to 0, each cycle.
REQ-020 state 1, pip_X[i] >= STEP: pip_X[i] <= pip_X[i]-STEP.
REQ-021 state 1, pip_X[i] < STEP (respawn): pip_X[i] <= pip_X[i]+P-STEP; pip_Y[i] <= new random Y; spacing preserved exactly.
REQ-022 Random Y: R = lfsr[8:0]; Y = SLOT_H + (R >= SCREEN_H-SLOT_H ? R-(SCREEN_H-SLOT_H) : R); result always in [SLOT_H, SCREEN_H-1].
REQ-023 LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1; advances every cycle rst_n is high, in all states; never all-zero.
REQ-024 Multiple pipes respawning in the same cycle SHALL use the same pre-advance LFSR value.
REQ-025 Score event, state 1 only: pipe i's pip_X goes from > SL to <= SL in one update; detected with any STEP, never on a respawn update.
REQ-026 Score events per cycle SHALL add their count; score saturates at 255; score_pulse asserted next cycle only if score changed.
REQ-027 state 2/3: pip_X, pip_Y, score hold; score_pulse 0.
REQ-028 A speed change SHALL take effect on the next tick with no position glitch.
REQ-029 A state change mid-run SHALL take effect on the same edge it is sampled.

Reset
REQ-030 rst_n low at a rising edge: pip_X = X0[i], pip_Y = Y0, score = 0, score_pulse = 0, lfsr = LFSR_SEED; this overrides state and speed.
REQ-031 Reset asserted mid-run SHALL restore all values in REQ-030 on that edge; no partial update.

Verification
REQ-032 Reset, then state=1, speed=0, 454 ticks -> pip_X[0]=286, score=1, score_pulse high on tick 455 only.
REQ-033 state=1, speed=0 from init, 740 ticks -> pip_X[0]=0; tick 741 -> pip_X[0]=779, pip_X[1]=259, pip_X[2]=519; pip_Y[0] in [100,479].
REQ-034 state=1, speed=3 from init -> tick 113 pip_X[0]=288, score 0; tick 114 pip_X[0]=284, score 1.
REQ-035 Run 50 ticks, state=2 for 20 cycles -> all outputs frozen; state=0 -> X0/Y0 restored, score 0.
REQ-036 Preload score near 255 (small-parameter build), continue scoring -> score holds 255, no further score_pulse.
REQ-037 rst_n low mid-run with state=1 -> REQ-030 values on that edge; LFSR resumes from LFSR_SEED.
